// File: rtl/pp_accumulator.sv
// Accumulates four Vedic half-width partial products into a 2*PP_W product (PP_W even, >= 4).
// Optional sticky carry-out flag on port ovf when PP_ACC_OVF_EN is defined.
module pp_accumulator #(
  parameter int PP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PP_W-1:0]   in_pp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*PP_W-1:0] out_prod
`ifdef PP_ACC_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int H  = PP_W / 2;
  localparam int AW = 2 * PP_W;

  typedef enum logic {
    ST_ACC,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   addend;
`ifdef PP_ACC_OVF_EN
  logic            ovf_q, ovf_d;
  logic [AW:0]     sum;
`else
  logic [AW-1:0]   sum;
`endif

  // Beat alignment: q0 at 0, q1/q2 at H, q3 at PP_W.
  always_comb begin
    addend = AW'(in_pp);
    case (cnt_q)
      2'd1, 2'd2: addend = AW'(in_pp) << H;
      2'd3:       addend = AW'(in_pp) << PP_W;
      default:    addend = AW'(in_pp);
    endcase
`ifdef PP_ACC_OVF_EN
    sum = {1'b0, acc_q} + {1'b0, addend};
`else
    sum = acc_q + addend;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
`ifdef PP_ACC_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          if (cnt_q == 2'd0) begin
            acc_d = AW'(in_pp);
`ifdef PP_ACC_OVF_EN
            ovf_d = 1'b0;
`endif
          end else begin
            acc_d = sum[AW-1:0];
`ifdef PP_ACC_OVF_EN
            ovf_d = ovf_q | sum[AW];
`endif
          end
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The consuming cycle never accepts a beat, since in_ready is 0 here.
        if (out_ready) begin
          state_d = ST_ACC;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = ST_ACC;
        cnt_d   = 2'd0;
      end
    endcase
    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      cnt_q       <= 2'd0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef PP_ACC_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef PP_ACC_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = acc_q;
`ifdef PP_ACC_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 The block SHALL have parameter PP_W, default 8, giving the partial-product width; PP_W SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_pp carries a valid partial product.
REQ-005 in_ready  output  1  block accepts in_pp this cycle.
REQ-006 in_pp  input  PP_W  partial product from a half-width Vedic multiplier unit.
REQ-007 out_valid  output  1  out_prod holds a completed product.
REQ-008 out_ready  input  1  downstream consumes out_prod this cycle.
REQ-009 out_prod  output  2*PP_W  accumulated full-width product.
REQ-010 ovf  output  1  carry out of the MSB occurred during accumulation; present only when PP_ACC_OVF_EN is defined.

Function
REQ-011 A beat SHALL be accepted in a cycle where in_valid and in_ready are both 1.
REQ-012 Beats SHALL arrive in fixed order: q0=al*bl, q1=ah*bl, q2=al*bh, q3=ah*bh; H=PP_W/2.
REQ-013 Beat alignment SHALL be: q0 shift 0; q1 and q2 shift H; q3 shift PP_W; all added into a 2*PP_W accumulator.
REQ-014 Accumulation SHALL be modulo 2^(2*PP_W); the carry out of the MSB SHALL be discarded from out_prod.
REQ-015 The FSM SHALL have states ACC (2-bit beat counter, 0..3) and DONE.
REQ-016 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 When beat 0 is accepted, the accumulator SHALL be loaded with q0 rather than added to its old value.
REQ-018 In ACC, an accepted beat SHALL increment the counter, and acceptance of beat 3 SHALL move the FSM to DONE.
REQ-019 With no accepted beat, counter and accumulator SHALL hold; gaps between beats are allowed.
REQ-020 In DONE, out_valid SHALL be 1 and in_ready SHALL be 0.
REQ-021 out_valid SHALL assert on the cycle after beat 3 is accepted (latency 1).
REQ-022 out_prod SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid and out_ready both 1, the FSM SHALL return to ACC with counter 0, and in_ready SHALL be 1 on the next cycle.
REQ-024 No beat SHALL be accepted in the cycle the result is consumed.
REQ-025 out_prod SHALL be driven from a register and SHALL keep its last value after consumption.
REQ-026 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 When rst=1 at a clock edge, the FSM SHALL go to ACC with counter 0, the accumulator SHALL be 0, out_valid=0, in_ready=1, and ovf=0.
REQ-028 Reset asserted mid-sequence or in DONE SHALL discard the partial result; no out_valid SHALL follow for that sequence.
REQ-029 rst SHALL take priority over a simultaneous handshake.

Configuration
REQ-030 Macro PP_ACC_OVF_EN, when defined: port ovf SHALL exist, SHALL be cleared at beat 0, SHALL be set sticky on any carry out of the accumulator MSB, and SHALL be valid with out_valid.
REQ-031 PP_ACC_OVF_EN undefined: port ovf SHALL be absent and carries SHALL be discarded; all other behaviour SHALL be identical.

Verification
REQ-032 PP_W=8; beats 0xE1,0xE1,0xE1,0xE1 back-to-back (0xFF*0xFF) -> out_valid one cycle after last beat; out_prod=0xFE01; ovf=0.
REQ-033 Beats 0x08,0x04,0x06,0x03 (0x12*0x34), with one idle cycle between each beat -> out_prod=0x03A8.
REQ-034 0x12*0x34 sequence with out_ready held 0 for 3 cycles -> out_valid and out_prod=0x03A8 held stable, in_ready=0 throughout; consumed on the 4th cycle; in_ready=1 next cycle.
REQ-035 Beats 0xFF x4 -> out_prod=0x1FDF; ovf=1 when PP_ACC_OVF_EN is defined; next product 0x03A8 reports ovf=0.
REQ-036 Accept 2 beats, pulse rst for 1 cycle, then send the 0x12*0x34 sequence -> out_valid only for the new sequence; out_prod=0x03A8.
